// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared write-back types and constants for the register-file
// write-port arbiter.
package merlin_wb_pkg;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_ALU = 2'd0;
  localparam req_idx_t REQ_LSU = 2'd1;
  localparam req_idx_t REQ_CSR = 2'd2;

  typedef struct packed {
    logic            wr;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wport_t;

  function automatic req_idx_t rr_next(
    input req_idx_t i
  );
    return (i == REQ_CSR) ? REQ_ALU : i + 2'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Request-side valid/ready bundle shared by the three
// write-back sources.
interface regfile_wb_arbiter_if #(
  parameter int P_XLEN = 32,
  parameter int P_NREQ = 3
);

  logic [P_NREQ-1:0]        req_valid_i;
  logic [5*P_NREQ-1:0]      req_addr_i;
  logic [P_XLEN*P_NREQ-1:0] req_data_i;
  logic [P_NREQ-1:0]        req_ready_o;

  modport master (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface

// File: rtl/wb_rr_select.sv
// Round-robin pick-two selector with same-destination
// conflict skipping.
module wb_rr_select
  import merlin_wb_pkg::*;
(
  input  logic [NREQ-1:0]   valid,
  input  logic [5*NREQ-1:0] addr,
  input  req_idx_t          ptr,
  output logic [NREQ-1:0]   grant,
  output req_idx_t          idx_a,
  output req_idx_t          idx_b,
  output logic              use_a,
  output logic              use_b,
  output req_idx_t          ptr_next
);

  req_idx_t   ord [NREQ];
  req_idx_t   cand;
  logic [4:0] cand_addr;
  logic [4:0] a_addr;
  logic       hit;

  always_comb begin
    ord[0]    = REQ_ALU;
    ord[1]    = REQ_LSU;
    ord[2]    = REQ_CSR;
    cand      = '0;
    cand_addr = '0;
    a_addr    = '0;
    hit       = 1'b0;
    grant     = '0;
    idx_a     = '0;
    idx_b     = '0;
    use_a     = 1'b0;
    use_b     = 1'b0;
    ptr_next  = ptr;

    unique case (1'b1)
      (ptr == REQ_LSU): begin
        ord[0] = REQ_LSU;
        ord[1] = REQ_CSR;
        ord[2] = REQ_ALU;
      end
      (ptr == REQ_CSR): begin
        ord[0] = REQ_CSR;
        ord[1] = REQ_ALU;
        ord[2] = REQ_LSU;
      end
      default: begin
        ord[0] = REQ_ALU;
        ord[1] = REQ_LSU;
        ord[2] = REQ_CSR;
      end
    endcase

    for (int k = 0; k < NREQ; k++) begin
      cand      = ord[k];
      cand_addr = addr[5*cand +: 5];
      // x0 never collides; it still burns a port slot
      hit = use_a && (cand_addr != 5'd0)
          && (cand_addr == a_addr);
      if (valid[cand] && !use_b && !hit) begin
        grant[cand] = 1'b1;
        ptr_next    = rr_next(cand);
        if (!use_a) begin
          use_a  = 1'b1;
          idx_a  = cand;
          a_addr = cand_addr;
        end else begin
          use_b = 1'b1;
          idx_b = cand;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares register-file ports A/B among
// ALU, LSU and CSR results with registered write ports.
module regfile_wb_arbiter
  import merlin_wb_pkg::*;
#(
  parameter int P_XLEN = 32,
  parameter int P_NREQ = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clk_en_i,
  regfile_wb_arbiter_if.slave req,
  output logic                wreg_a_wr_o,
  output logic [4:0]          wreg_a_addr_o,
  output logic [P_XLEN-1:0]   wreg_a_data_o,
  output logic                wreg_b_wr_o,
  output logic [4:0]          wreg_b_addr_o,
  output logic [P_XLEN-1:0]   wreg_b_data_o,
  output logic [31:0]         pend_mask_o
);

  req_idx_t          rr_ptr;
  req_idx_t          ptr_next;
  req_idx_t          idx_a;
  req_idx_t          idx_b;
  logic [P_NREQ-1:0] grant;
  logic              use_a;
  logic              use_b;
  logic [4:0]        a_addr;
  logic [4:0]        b_addr;
  logic [P_XLEN-1:0] a_data;
  logic [P_XLEN-1:0] b_data;
  wport_t            port_a;
  wport_t            port_b;

  wb_rr_select u_sel (
    .valid    (req.req_valid_i),
    .addr     (req.req_addr_i),
    .ptr      (rr_ptr),
    .grant    (grant),
    .idx_a    (idx_a),
    .idx_b    (idx_b),
    .use_a    (use_a),
    .use_b    (use_b),
    .ptr_next (ptr_next)
  );

  assign req.req_ready_o =
    (clk_en_i && !reset_i) ? grant : '0;

  assign a_addr = req.req_addr_i[5*idx_a +: 5];
  assign b_addr = req.req_addr_i[5*idx_b +: 5];
  assign a_data = req.req_data_i[P_XLEN*idx_a +: P_XLEN];
  assign b_data = req.req_data_i[P_XLEN*idx_b +: P_XLEN];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr <= '0;
      port_a <= '0;
      port_b <= '0;
    end else if (clk_en_i) begin
      rr_ptr    <= ptr_next;
      port_a.wr <= use_a && (a_addr != 5'd0);
      port_b.wr <= use_b && (b_addr != 5'd0);
      // idle port keeps its stale addr/data
      if (use_a) begin
        port_a.addr <= a_addr;
        port_a.data <= a_data;
      end
      if (use_b) begin
        port_b.addr <= b_addr;
        port_b.data <= b_data;
      end
    end
  end

  assign wreg_a_wr_o   = port_a.wr;
  assign wreg_a_addr_o = port_a.addr;
  assign wreg_a_data_o = port_a.data;
  assign wreg_b_wr_o   = port_b.wr;
  assign wreg_b_addr_o = port_b.addr;
  assign wreg_b_data_o = port_b.data;

  always_comb begin
    pend_mask_o = '0;
    if (port_a.wr) pend_mask_o[port_a.addr] = 1'b1;
    if (port_b.wr) pend_mask_o[port_b.addr] = 1'b1;
    pend_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: expected writes queued at grant time,
// popped by a register-file commit monitor.
module tb_regfile_wb_arbiter;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        clk_en = 1'b1;
  logic        wa_wr;
  logic        wb_wr;
  logic [4:0]  wa_addr;
  logic [4:0]  wb_addr;
  logic [31:0] wa_data;
  logic [31:0] wb_data;
  logic [31:0] pend;

  regfile_wb_arbiter_if #(
    .P_XLEN (32),
    .P_NREQ (3)
  ) bus ();

  regfile_wb_arbiter #(
    .P_XLEN (32),
    .P_NREQ (3)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .clk_en_i      (clk_en),
    .req           (bus.slave),
    .wreg_a_wr_o   (wa_wr),
    .wreg_a_addr_o (wa_addr),
    .wreg_a_data_o (wa_data),
    .wreg_b_wr_o   (wb_wr),
    .wreg_b_addr_o (wb_addr),
    .wreg_b_data_o (wb_data),
    .pend_mask_o   (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exq [$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic commit(input logic [4:0] a,
                        input logic [31:0] d);
    wr_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL rf_write: got x%0d=%h expected none",
               a, d);
    end else begin
      e = exq.pop_front();
      if (a !== e.a || d !== e.d) begin
        errors++;
        $display("FAIL rf_write: got x%0d=%h expected x%0d=%h",
                 a, d, e.a, e.d);
      end
    end
    rf[a] = d;
  endtask

  // register file commits what is presented at an enabled edge
  always @(negedge clk) begin
    if (clk_en && !reset) begin
      if (wa_wr) commit(wa_addr, wa_data);
      if (wb_wr) commit(wb_addr, wb_data);
    end
  end

  task automatic push(input logic [4:0] a,
                      input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exq.push_back(e);
  endtask

  task automatic set_req(input int n, input logic v,
                         input logic [4:0] a,
                         input logic [31:0] d);
    bus.req_valid_i[n]       = v;
    bus.req_addr_i[5*n +: 5] = a;
    bus.req_data_i[32*n +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sdata(input int n,
                                        input int s);
    return 32'hC000_0000 | 32'(n << 8) | 32'(s);
  endfunction

  logic [2:0] rtab [3];
  int         atab [3];
  int         btab [3];
  int         seq  [3];
  int         gcnt [3];
  int         wt   [3];
  int         maxw;

  initial begin
    rtab = '{3'b011, 3'b101, 3'b110};
    atab = '{0, 2, 1};
    btab = '{1, 0, 2};
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 3; i++) begin
      seq[i]  = 0;
      gcnt[i] = 0;
      wt[i]   = 0;
    end
    maxw = 0;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;

    // reset with three valid requests
    set_req(0, 1'b1, 5'd1, 32'h1000_0001);
    set_req(1, 1'b1, 5'd2, 32'h1000_0002);
    set_req(2, 1'b1, 5'd3, 32'h1000_0003);
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst_wr_a", 32'(wa_wr), 32'h0);
    chk("rst_wr_b", 32'(wb_wr), 32'h0);
    chk("rst_addr_a", 32'(wa_addr), 32'h0);
    chk("rst_data_b", wb_data, 32'h0);
    chk("rst_pend", pend, 32'h0);
    reset = 1'b0;
    #1;
    chk("p1_ready", 32'(bus.req_ready_o), 32'h3);
    push(5'd1, 32'h1000_0001);
    push(5'd2, 32'h1000_0002);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("p1_ready2", 32'(bus.req_ready_o), 32'h4);
    chk("p1_addr_a", 32'(wa_addr), 32'd1);
    chk("p1_data_a", wa_data, 32'h1000_0001);
    chk("p1_addr_b", 32'(wb_addr), 32'd2);
    chk("p1_data_b", wb_data, 32'h1000_0002);
    chk("p1_pend", pend, 32'h6);
    push(5'd3, 32'h1000_0003);
    tick();
    chk("p1_pend2", pend, 32'h8);
    chk("p1_wr_b_idle", 32'(wb_wr), 32'h0);

    // same-destination conflict, rr_ptr = 0
    set_req(0, 1'b1, 5'd5, 32'hE000_0000);
    set_req(1, 1'b1, 5'd5, 32'hE000_0001);
    set_req(2, 1'b1, 5'd7, 32'hE000_0002);
    #1;
    chk("p2_ready", 32'(bus.req_ready_o), 32'h5);
    push(5'd5, 32'hE000_0000);
    push(5'd7, 32'hE000_0002);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    chk("p2_ready2", 32'(bus.req_ready_o), 32'h2);
    chk("p2_pend", pend, 32'hA0);
    chk("p2_data_a", wa_data, 32'hE000_0000);
    push(5'd5, 32'hE000_0001);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();

    // x0 request, rr_ptr steered to 1
    set_req(0, 1'b1, 5'd4, 32'hF000_0000);
    #1;
    chk("p3_ready0", 32'(bus.req_ready_o), 32'h1);
    push(5'd4, 32'hF000_0000);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd0, 32'hF000_0001);
    set_req(2, 1'b1, 5'd9, 32'hF000_0002);
    #1;
    chk("p3_ready", 32'(bus.req_ready_o), 32'h6);
    push(5'd9, 32'hF000_0002);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    chk("p3_wr_a", 32'(wa_wr), 32'h0);
    chk("p3_wr_b", 32'(wb_wr), 32'h1);
    chk("p3_addr_b", 32'(wb_addr), 32'd9);
    chk("p3_pend", pend, 32'h200);
    tick();

    // continuous stream to x10..x12
    for (int n = 0; n < 3; n++)
      set_req(n, 1'b1, 5'(10 + n), sdata(n, seq[n]));
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("p4_ready", 32'(bus.req_ready_o),
          32'(rtab[c % 3]));
      push(5'(10 + atab[c % 3]),
           sdata(atab[c % 3], seq[atab[c % 3]]));
      push(5'(10 + btab[c % 3]),
           sdata(btab[c % 3], seq[btab[c % 3]]));
      for (int n = 0; n < 3; n++) begin
        if (bus.req_ready_o[n]) begin
          gcnt[n]++;
          wt[n] = 0;
        end else begin
          wt[n]++;
          if (wt[n] > maxw) maxw = wt[n];
        end
      end
      tick();
      for (int n = 0; n < 3; n++) begin
        if (rtab[c % 3][n]) begin
          seq[n]++;
          set_req(n, 1'b1, 5'(10 + n), sdata(n, seq[n]));
        end
      end
    end
    chk("p4_grants0", 32'(gcnt[0]), 32'd4);
    chk("p4_grants1", 32'(gcnt[1]), 32'd4);
    chk("p4_grants2", 32'(gcnt[2]), 32'd4);
    chk("p4_max_wait_ok", 32'(maxw <= 2), 32'd1);

    // clock enable dropped mid-stream
    #1;
    chk("p5_ready", 32'(bus.req_ready_o), 32'h3);
    push(5'd10, sdata(0, seq[0]));
    push(5'd11, sdata(1, seq[1]));
    tick();
    for (int n = 0; n < 2; n++) begin
      seq[n]++;
      set_req(n, 1'b1, 5'(10 + n), sdata(n, seq[n]));
    end
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("p5_hold_ready", 32'(bus.req_ready_o), 32'h0);
      chk("p5_hold_pend", pend, 32'hC00);
      chk("p5_hold_data_a", wa_data, sdata(0, 4));
      chk("p5_hold_addr_b", 32'(wb_addr), 32'd11);
      tick();
    end
    clk_en = 1'b1;
    #1;
    chk("p5_resume", 32'(bus.req_ready_o), 32'h5);
    push(5'd12, sdata(2, seq[2]));
    push(5'd10, sdata(0, seq[0]));
    tick();
    for (int n = 0; n < 3; n++) set_req(n, 1'b0, 5'd0, 32'h0);
    tick();
    tick();

    // reset right after a grant
    set_req(1, 1'b1, 5'd20, 32'h2000_0014);
    #1;
    chk("p6_ready", 32'(bus.req_ready_o), 32'h2);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b1, 5'd21, 32'h2000_0015);
    reset = 1'b1;
    #1;
    chk("p6_rst_ready", 32'(bus.req_ready_o), 32'h0);
    tick();
    chk("p6_wr_a", 32'(wa_wr), 32'h0);
    chk("p6_addr_a", 32'(wa_addr), 32'h0);
    chk("p6_data_a", wa_data, 32'h0);
    chk("p6_pend", pend, 32'h0);
    reset = 1'b0;
    #1;
    chk("p6_ready2", 32'(bus.req_ready_o), 32'h4);
    push(5'd21, 32'h2000_0015);
    tick();
    set_req(2, 1'b0, 5'd0, 32'h0);
    tick();
    tick();

    chk("queue_left", 32'(exq.size()), 32'd0);
    chk("rf_x20", rf[20], 32'h0);
    chk("rf_x5", rf[5], 32'hE000_0001);
    chk("rf_x9", rf[9], 32'hF000_0002);
    chk("rf_x21", rf[21], 32'h2000_0015);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
